// File: rtl/input_debouncer_if.sv
// Raw switch levels in, debounced levels and edge pulses out, for the two-channel debouncer.
// master drives the raw levels; slave is the debouncer itself.
interface input_debouncer_if;
    logic x_raw;
    logic y_raw;
    logic x_clean;
    logic y_clean;
    logic x_rise;
    logic x_fall;
    logic y_rise;
    logic y_fall;

    modport master (
        output x_raw, y_raw,
        input  x_clean, y_clean, x_rise, x_fall, y_rise, y_fall
    );

    modport slave (
        input  x_raw, y_raw,
        output x_clean, y_clean, x_rise, x_fall, y_rise, y_fall
    );
endinterface

// File: rtl/input_debouncer.sv
// Purpose: two independent channels of 2-FF sync + debounce, with registered rise/fall pulses.
// Latency: a steady raw level reaches clean (and its pulse) DB_CYCLES+2 edges after first being sampled.
// Backpressure: none; free-running level conditioner, outputs are valid every cycle.
module input_debouncer #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input_debouncer_if.slave io
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Bit 0 is channel x, bit 1 is channel y throughout.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       clean_q;
    logic [1:0]       clean_d;
    logic [1:0]       rise_q;
    logic [1:0]       rise_d;
    logic [1:0]       fall_q;
    logic [1:0]       fall_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    assign raw = {io.y_raw, io.x_raw};

    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
        end
        // A matching sample discards any partial count; the count only survives unbroken runs.
        for (int i = 0; i < 2; i++) begin
            if (sync2[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = sync2[i];
                    rise_d[i]  = sync2[i];
                    fall_d[i]  = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io.x_clean = clean_q[0];
    assign io.y_clean = clean_q[1];
    assign io.x_rise  = rise_q[0];
    assign io.x_fall  = fall_q[0];
    assign io.y_rise  = rise_q[1];
    assign io.y_fall  = fall_q[1];
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: hand sequences, an OR-gate truth-table sweep and random bounce
// traffic, all checked against a window-based reference model of the debounce rule.
module tb_input_debouncer;
    localparam int DB = 4;

    logic clk;
    logic rst_n;

    input_debouncer_if io ();

    input_debouncer #(
        .DB_CYCLES (DB),
        .CNT_W     (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: hist[ch][k] is the synchronised level seen at edge k after release.
    // A channel accepts at edge n when the last DB views all disagree with clean and none
    // of them precede the previous acceptance.
    bit hist [2][$];
    int n_edge;
    int last_acc [2];
    bit m_clean [2];
    bit m_rise [2];
    bit m_fall [2];

    typedef struct {
        bit x;
        bit y;
        bit xc;
        bit yc;
        int tog_at;
    } vec_t;

    vec_t tbl [5];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            hist[ch].delete();
            hist[ch].push_back(1'b0);
            hist[ch].push_back(1'b0);
            last_acc[ch] = -1;
            m_clean[ch]  = 1'b0;
            m_rise[ch]   = 1'b0;
            m_fall[ch]   = 1'b0;
        end
        n_edge = 0;
    endfunction

    function automatic void model_edge(bit rx, bit ry, bit rr);
        bit raw;
        bit ok;
        if (!rr) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < 2; ch++) begin
            raw         = (ch == 0) ? rx : ry;
            m_rise[ch]  = 1'b0;
            m_fall[ch]  = 1'b0;
            if (n_edge - last_acc[ch] >= DB) begin
                ok = 1'b1;
                for (int k = n_edge - DB + 1; k <= n_edge; k++) begin
                    if (hist[ch][k] == m_clean[ch]) ok = 1'b0;
                end
                if (ok) begin
                    m_clean[ch]  = !m_clean[ch];
                    m_rise[ch]   = m_clean[ch];
                    m_fall[ch]   = !m_clean[ch];
                    last_acc[ch] = n_edge;
                end
            end
            hist[ch].push_back(raw);
        end
        n_edge++;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One clock edge: capture what the DUT will sample, advance the model, compare #1 later.
    task automatic step();
        bit rx;
        bit ry;
        bit rr;
        rx = io.x_raw;
        ry = io.y_raw;
        rr = rst_n;
        @(posedge clk);
        model_edge(rx, ry, rr);
        #1;
        chk("x_clean", io.x_clean, m_clean[0]);
        chk("y_clean", io.y_clean, m_clean[1]);
        chk("x_rise",  io.x_rise,  m_rise[0]);
        chk("x_fall",  io.x_fall,  m_fall[0]);
        chk("y_rise",  io.y_rise,  m_rise[1]);
        chk("y_fall",  io.y_fall,  m_fall[1]);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x_clean"}, io.x_clean, 1'b0);
        chk({tag, "_y_clean"}, io.y_clean, 1'b0);
        chk({tag, "_x_rise"},  io.x_rise,  1'b0);
        chk({tag, "_x_fall"},  io.x_fall,  1'b0);
        chk({tag, "_y_rise"},  io.y_rise,  1'b0);
        chk({tag, "_y_fall"},  io.y_fall,  1'b0);
    endtask

    initial begin
        int nr;
        int nf;
        int at;
        int atx;
        int aty;
        int tog;
        int hx;
        int hy;
        logic prev_or;
        logic cur_or;

        tbl[0] = '{x: 1'b0, y: 1'b0, xc: 1'b0, yc: 1'b0, tog_at: 0};
        tbl[1] = '{x: 1'b1, y: 1'b0, xc: 1'b1, yc: 1'b0, tog_at: 6};
        tbl[2] = '{x: 1'b1, y: 1'b1, xc: 1'b1, yc: 1'b1, tog_at: 0};
        tbl[3] = '{x: 1'b0, y: 1'b1, xc: 1'b0, yc: 1'b1, tog_at: 0};
        tbl[4] = '{x: 1'b0, y: 1'b0, xc: 1'b0, yc: 1'b0, tog_at: 6};

        rst_n    = 1'b0;
        io.x_raw = 1'b1;
        io.y_raw = 1'b1;
        model_reset();
        #12;
        chk_all_zero("reset");
        #13;
        rst_n    = 1'b1;
        io.x_raw = 1'b0;
        io.y_raw = 1'b0;
        steps(3);

        // 1: single clean rise on x
        io.x_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 5) chk("t1_x_clean_early", io.x_clean, 1'b0);
            if (k == 6) begin
                chk("t1_x_clean", io.x_clean, 1'b1);
                chk("t1_x_rise", io.x_rise, 1'b1);
            end
            if (k == 7) chk("t1_x_rise_drop", io.x_rise, 1'b0);
            chk("t1_x_fall", io.x_fall, 1'b0);
        end

        // 2: 3-cycle pulse on y is rejected
        nr = 0;
        nf = 0;
        io.y_raw = 1'b1;
        steps(3);
        io.y_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (io.y_rise) nr++;
            if (io.y_fall) nf++;
            if (io.y_clean) nr += 100;
        end
        chk_int("t2_y_rise_or_clean", nr, 0);
        chk_int("t2_y_fall", nf, 0);

        // 3: bounce then hold on x
        io.x_raw = 1'b0;
        steps(8);
        io.x_raw = 1'b1; step();
        io.x_raw = 1'b0; step();
        io.x_raw = 1'b1; step();
        io.x_raw = 1'b0; step();
        io.x_raw = 1'b1;
        nr = 0;
        at = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (io.x_rise) begin
                nr++;
                if (at == 0) at = k;
            end
        end
        chk_int("t3_rise_cnt", nr, 1);
        chk_int("t3_rise_at", at, 6);

        // 4: simultaneous fall on both channels
        io.y_raw = 1'b1;
        steps(8);
        io.x_raw = 1'b0;
        io.y_raw = 1'b0;
        atx = 0;
        aty = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (io.x_fall && atx == 0) atx = k;
            if (io.y_fall && aty == 0) aty = k;
            if (k == 6) begin
                chk("t4_x_clean", io.x_clean, 1'b0);
                chk("t4_y_clean", io.y_clean, 1'b0);
            end
        end
        chk_int("t4_x_fall_at", atx, 6);
        chk_int("t4_y_fall_at", aty, 6);

        // 5: async reset mid-count, y already clean high
        io.y_raw = 1'b1;
        steps(8);
        chk("t5_y_clean_pre", io.y_clean, 1'b1);
        io.x_raw = 1'b1;
        steps(3);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("t5_async");
        steps(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 5) chk("t5_x_clean_early", io.x_clean, 1'b0);
            if (k == 6) begin
                chk("t5_x_clean", io.x_clean, 1'b1);
                chk("t5_x_rise", io.x_rise, 1'b1);
                chk("t5_y_rise", io.y_rise, 1'b1);
            end
        end

        // 6: truth-table sweep feeding an OR gate
        io.x_raw = 1'b0;
        io.y_raw = 1'b0;
        steps(10);
        for (int v = 0; v < 5; v++) begin
            io.x_raw = tbl[v].x;
            io.y_raw = tbl[v].y;
            prev_or  = io.x_clean | io.y_clean;
            tog = 0;
            at  = 0;
            for (int k = 1; k <= 20; k++) begin
                step();
                cur_or = io.x_clean | io.y_clean;
                if (cur_or != prev_or) begin
                    tog++;
                    if (at == 0) at = k;
                end
                prev_or = cur_or;
            end
            chk_int($sformatf("t6_or_toggles_%0d", v), tog, (tbl[v].tog_at != 0) ? 1 : 0);
            chk_int($sformatf("t6_or_toggle_at_%0d", v), at, tbl[v].tog_at);
            chk($sformatf("t6_x_clean_%0d", v), io.x_clean, tbl[v].xc);
            chk($sformatf("t6_y_clean_%0d", v), io.y_clean, tbl[v].yc);
            chk($sformatf("t6_or_%0d", v), cur_or, tbl[v].xc | tbl[v].yc);
        end

        // Random bouncing traffic with independent hold lengths per channel
        hx = 0;
        hy = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hx == 0) begin
                io.x_raw = 1'($urandom_range(0, 1));
                hx = $urandom_range(1, 7);
            end
            if (hy == 0) begin
                io.y_raw = 1'($urandom_range(0, 1));
                hy = $urandom_range(1, 7);
            end
            hx--;
            hy--;
            step();
        end

        // Raw toggling every cycle never changes clean
        io.x_raw = 1'b1;
        io.y_raw = 1'b1;
        steps(10);
        for (int i = 0; i < 40; i++) begin
            io.x_raw = ~io.x_raw;
            io.y_raw = ~io.y_raw;
            step();
        end
        chk("toggle_x_clean_hold", io.x_clean, 1'b1);
        chk("toggle_y_clean_hold", io.y_clean, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
